// File: rtl/ame_approx_pkg.sv
// Shared constants and lane result type for the AME number approximator.
// Build option AME_APPROX_ROUND_EN selects round-to-nearest instead of truncation.
package ame_approx_pkg;

  localparam int unsigned AME_DATA_BITS = 64;
  localparam int unsigned AME_MANT_BITS = 4;
  localparam int unsigned AME_EXP_BITS  = $clog2(AME_DATA_BITS);

  function automatic int unsigned ame_exp_bits(input int unsigned data_bits);
    return $clog2(data_bits);
  endfunction

  typedef struct packed {
    logic [AME_DATA_BITS-1:0] data;
    logic [AME_MANT_BITS-1:0] mant;
    logic [AME_EXP_BITS-1:0]  exp;
    logic                     sign;
    logic                     zero;
  } ame_lane_res_t;

endpackage

// File: rtl/ame_lzd.sv
// Combinational leading-one detector: position of the highest set bit plus zero flag.
module ame_lzd
  import ame_approx_pkg::*;
#(
  parameter int unsigned DATA_BITS = AME_DATA_BITS,
  parameter int unsigned POS_BITS  = ame_exp_bits(DATA_BITS)
) (
  input  logic [DATA_BITS-1:0] i_val,
  output logic [POS_BITS-1:0]  o_pos,
  output logic                 o_zero
);

  always_comb begin
    o_pos = '0;
    for (int unsigned i = 0; i < DATA_BITS; i++) begin
      if (i_val[i]) o_pos = POS_BITS'(i);
    end
  end

  assign o_zero = (i_val == '0);

endmodule

// File: rtl/ame_num_approx_pipe.sv
// Multi-lane two-stage number approximator with valid/ready backpressure.
// Define AME_APPROX_ROUND_EN for round-to-nearest; default build truncates.
module ame_num_approx_pipe
  import ame_approx_pkg::*;
#(
  parameter int unsigned DATA_BITS = AME_DATA_BITS,
  parameter int unsigned MANT_BITS = AME_MANT_BITS,
  parameter int unsigned LANES     = 4,
  parameter int unsigned EXP_BITS  = ame_exp_bits(DATA_BITS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [LANES*DATA_BITS-1:0]    in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [LANES*DATA_BITS-1:0]    out_data_o,
  output logic [LANES*MANT_BITS-1:0]    out_mant_o,
  output logic [LANES*EXP_BITS-1:0]     out_exp_o,
  output logic [LANES-1:0]              out_sign_o,
  output logic [LANES-1:0]              out_zero_o
);

  logic r1_valid;
  logic r2_valid;
  logic w_s2_adv;
  logic w_s1_load;
  logic w_s2_load;

  // Stage 2 can take a new beat when empty or when its beat leaves this cycle.
  assign w_s2_adv    = !r2_valid | out_ready_i;
  assign w_s2_load   = r1_valid & w_s2_adv;
  assign in_ready_o  = !r1_valid | w_s2_load;
  assign w_s1_load   = in_valid_i & in_ready_o;
  assign out_valid_o = r2_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else begin
      if (in_ready_o) r1_valid <= in_valid_i;
      if (w_s2_adv)   r2_valid <= r1_valid;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_BITS-1:0] w_x;
    logic [DATA_BITS-1:0] w_u;
    logic [EXP_BITS-1:0]  w_pos;
    logic                 w_zero;

    logic [DATA_BITS-1:0] r1_u;
    logic [EXP_BITS-1:0]  r1_pos;
    logic                 r1_zero;
    logic                 r1_sign;

    logic [EXP_BITS-1:0]  w_sh;
    logic [MANT_BITS-1:0] w_q;
    logic [MANT_BITS:0]   w_sum;
    logic [MANT_BITS-1:0] w_mant;
    logic [EXP_BITS-1:0]  w_exp;
    logic [DATA_BITS-1:0] w_data;

    logic [DATA_BITS-1:0] r2_data;
    logic [MANT_BITS-1:0] r2_mant;
    logic [EXP_BITS-1:0]  r2_exp;
    logic                 r2_sign;
    logic                 r2_zero;

    assign w_x = in_data_i[k*DATA_BITS +: DATA_BITS];
    assign w_u = w_x[DATA_BITS-1] ? ('0 - w_x) : w_x;

    ame_lzd #(
      .DATA_BITS (DATA_BITS),
      .POS_BITS  (EXP_BITS)
    ) u_lzd (
      .i_val  (w_u),
      .o_pos  (w_pos),
      .o_zero (w_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r1_u    <= '0;
        r1_pos  <= '0;
        r1_zero <= 1'b0;
        r1_sign <= 1'b0;
      end else if (w_s1_load) begin
        r1_u    <= w_u;
        r1_pos  <= w_pos;
        r1_zero <= w_zero;
        r1_sign <= w_x[DATA_BITS-1];
      end
    end

    always_comb begin
      w_sh   = '0;
      w_q    = '0;
      w_sum  = '0;
      w_mant = '0;
      w_exp  = '0;
      w_data = '0;
      if (r1_zero) begin
        w_data = '0;
      end else if (r1_pos < EXP_BITS'(MANT_BITS)) begin
        w_mant = r1_u[MANT_BITS-1:0];
        w_data = r1_u;
      end else begin
        w_sh  = r1_pos - EXP_BITS'(MANT_BITS - 1);
        w_q   = MANT_BITS'(r1_u >> w_sh);
        w_sum = {1'b0, w_q};
`ifdef AME_APPROX_ROUND_EN
        w_sum = w_sum + (MANT_BITS+1)'(r1_u[w_sh - EXP_BITS'(1)]);
`endif
        // Mantissa overflow renormalises to 100..0 with one more shift.
        if (w_sum[MANT_BITS]) begin
          w_mant = {1'b1, {(MANT_BITS-1){1'b0}}};
          w_exp  = w_sh + EXP_BITS'(1);
        end else begin
          w_mant = w_sum[MANT_BITS-1:0];
          w_exp  = w_sh;
        end
        w_data = DATA_BITS'(w_mant) << w_exp;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r2_data <= '0;
        r2_mant <= '0;
        r2_exp  <= '0;
        r2_sign <= 1'b0;
        r2_zero <= 1'b0;
      end else if (w_s2_load) begin
        r2_data <= w_data;
        r2_mant <= w_mant;
        r2_exp  <= w_exp;
        r2_sign <= r1_sign;
        r2_zero <= r1_zero;
      end
    end

    assign out_data_o[k*DATA_BITS +: DATA_BITS] = r2_data;
    assign out_mant_o[k*MANT_BITS +: MANT_BITS] = r2_mant;
    assign out_exp_o[k*EXP_BITS +: EXP_BITS]    = r2_exp;
    assign out_sign_o[k]                        = r2_sign;
    assign out_zero_o[k]                        = r2_zero;
  end

endmodule

// File: tb/tb_ame_num_approx_pipe.sv
// Scoreboard bench for ame_num_approx_pipe; honours AME_APPROX_ROUND_EN like the RTL.
module tb_ame_num_approx_pipe;
  import ame_approx_pkg::*;

  localparam int DW = 64;
  localparam int MW = 4;
  localparam int L  = 4;
  localparam int EW = 6;
  localparam int VW = 1 + L*DW + L*MW + L*EW + 2*L;

  typedef struct packed {
    logic [L*DW-1:0] data;
    logic [L*MW-1:0] mant;
    logic [L*EW-1:0] exp;
    logic [L-1:0]    sign;
    logic [L-1:0]    zero;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [L*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [L*DW-1:0] out_data;
  logic [L*MW-1:0] out_mant;
  logic [L*EW-1:0] out_exp;
  logic [L-1:0]    out_sign;
  logic [L-1:0]    out_zero;

  int    n_pass = 0;
  int    n_total = 0;
  int    beats_in = 0;
  int    beats_out = 0;
  logic  rand_done = 1'b0;
  beat_t q[$];

  ame_num_approx_pipe #(
    .DATA_BITS (DW),
    .MANT_BITS (MW),
    .LANES     (L)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_mant_o  (out_mant),
    .out_exp_o   (out_exp),
    .out_sign_o  (out_sign),
    .out_zero_o  (out_zero)
  );

  always #5 clk = ~clk;

  // Reference: value = round(|x|) to MW significant bits, as mantissa * 2^exp.
  function automatic ame_lane_res_t model_lane(input logic [DW-1:0] x);
    ame_lane_res_t r;
    logic [DW-1:0] u;
    logic [DW-1:0] m;
    int p;
    int e;
    r = '0;
    u = x[DW-1] ? (64'd0 - x) : x;
    if (u == 64'd0) begin
      r.zero = 1'b1;
      return r;
    end
    r.sign = x[DW-1];
    p = 0;
    while ((u >> (p + 1)) != 64'd0) p++;
    if (p < MW) begin
      r.mant = u[MW-1:0];
      r.data = u;
      return r;
    end
    e = p - MW + 1;
    m = u >> e;
`ifdef AME_APPROX_ROUND_EN
    m = m + {63'd0, u[e-1]};
`endif
    if (m == 64'd16) begin
      m = m >> 1;
      e = e + 1;
    end
    r.mant = m[MW-1:0];
    r.exp  = 6'(e);
    r.data = m << e;
    return r;
  endfunction

  function automatic beat_t model_beat(input logic [L*DW-1:0] d);
    beat_t b;
    ame_lane_res_t r;
    b = '0;
    for (int k = 0; k < L; k++) begin
      r = model_lane(d[k*DW +: DW]);
      b.data[k*DW +: DW] = r.data;
      b.mant[k*MW +: MW] = r.mant;
      b.exp[k*EW +: EW]  = r.exp;
      b.sign[k]          = r.sign;
      b.zero[k]          = r.zero;
    end
    return b;
  endfunction

  function automatic logic [VW-1:0] cur_out();
    return {out_valid, out_data, out_mant, out_exp, out_sign, out_zero};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic monitor();
    beat_t          e;
    logic [VW-1:0]  prev = '0;
    logic           prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats_in  -= q.size();
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("hold_stable", cur_out(), prev);
        if (in_valid && in_ready) begin
          q.push_back(model_beat(in_data));
          beats_in++;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_out: got data %0h, required no output", out_data);
          end else begin
            e = q.pop_front();
            chk("sb_data", VW'(out_data), VW'(e.data));
            chk("sb_mant", VW'(out_mant), VW'(e.mant));
            chk("sb_exp",  VW'(out_exp),  VW'(e.exp));
            chk("sb_sign", VW'(out_sign), VW'(e.sign));
            chk("sb_zero", VW'(out_zero), VW'(e.zero));
            beats_out++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev       = cur_out();
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [L*DW-1:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        n_total++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [L*DW-1:0] d,
                          input logic [L*DW-1:0] x_data, input logic [L*MW-1:0] x_mant,
                          input logic [L*EW-1:0] x_exp, input logic [L-1:0] x_sign,
                          input logic [L-1:0] x_zero);
    send_beat(d);
    chk({name, "_lat1_valid"}, VW'(out_valid), VW'(1'b0));
    @(posedge clk);
    #1;
    chk({name, "_lat2_valid"}, VW'(out_valid), VW'(1'b1));
    chk({name, "_data"}, VW'(out_data), VW'(x_data));
    chk({name, "_mant"}, VW'(out_mant), VW'(x_mant));
    chk({name, "_exp"},  VW'(out_exp),  VW'(x_exp));
    chk({name, "_sign"}, VW'(out_sign), VW'(x_sign));
    chk({name, "_zero"}, VW'(out_zero), VW'(x_zero));
  endtask

  task automatic drain();
    int w = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (w >= 500) begin
      n_total++;
      $display("FAIL drain_timeout: %0d beats still pending, required 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_lane();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'h8000_0000_0000_0000;
      2:       v = 64'($urandom_range(0, 31));
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    if ($urandom_range(0, 1) == 1) v = 64'd0 - v;
    return v;
  endfunction

  initial begin
    logic [L*DW-1:0] d;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", cur_out(), '0);
    chk("reset_in_ready", VW'(in_ready), VW'(1'b1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    directed("basic", {64'd5, 64'd0, 64'd0 - 64'hB7, 64'hB7},
             {64'd5, 64'd0, 64'd176, 64'd176}, {4'h5, 4'h0, 4'hB, 4'hB},
             {6'd0, 6'd0, 6'd4, 6'd4}, 4'b0010, 4'b0100);
`ifdef AME_APPROX_ROUND_EN
    directed("round", {64'd0, 64'd0, 64'hF8, 64'hBC},
             {64'd0, 64'd0, 64'd256, 64'd192}, {4'h0, 4'h0, 4'h8, 4'hC},
             {6'd0, 6'd0, 6'd5, 6'd4}, 4'b0000, 4'b1100);
    directed("extreme", {64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
             {64'd0, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000},
             {4'h0, 4'h0, 4'h8, 4'h8}, {6'd0, 6'd0, 6'd60, 6'd60}, 4'b0001, 4'b1100);
`else
    directed("round", {64'd0, 64'd0, 64'hF8, 64'hBC},
             {64'd0, 64'd0, 64'd240, 64'd176}, {4'h0, 4'h0, 4'hF, 4'hB},
             {6'd0, 6'd0, 6'd4, 6'd4}, 4'b0000, 4'b1100);
    directed("extreme", {64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
             {64'd0, 64'd0, 64'h7800_0000_0000_0000, 64'h8000_0000_0000_0000},
             {4'h0, 4'h0, 4'hF, 4'h8}, {6'd0, 6'd0, 6'd59, 6'd60}, 4'b0001, 4'b1100);
`endif
    drain();

    // Backpressure: two beats fill the pipe, the rest wait for release.
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      d = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      send_beat(d);
      if (i == 1) chk("bp_in_ready_low", VW'(in_ready), VW'(1'b0));
    end
    drain();

    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          send_beat({rand_lane(), rand_lane(), rand_lane(), rand_lane()});
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset with two beats in flight, then a fresh beat.
    out_ready = 1'b0;
    send_beat({rand_lane(), rand_lane(), rand_lane(), rand_lane()});
    send_beat({rand_lane(), rand_lane(), rand_lane(), rand_lane()});
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", cur_out(), '0);
    chk("async_reset_in_ready", VW'(in_ready), VW'(1'b1));
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    d = {64'd0 - 64'h1234, 64'd9, 64'h00F0_0000_0000_0001, 64'd0};
    directed("post_reset", d, model_beat(d).data, model_beat(d).mant,
             model_beat(d).exp, model_beat(d).sign, model_beat(d).zero);
    drain();

    chk("beats_in_eq_out", VW'(beats_out), VW'(beats_in));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ame_num_approx_pipe.md
# ame_num_approx_pipe

Multi-lane, pipelined successor of the single-lane 64-bit number approximator in the AME (affine motion estimation) datapath. Each lane takes a signed two's-complement integer, keeps only its MANT_BITS most significant magnitude bits with optional round-to-nearest, and returns the approximated magnitude, mantissa/exponent pair, sign and zero flag. All lanes share one valid/ready handshake. The two-stage pipeline supports full backpressure and feeds the downstream multiply-free affine parameter stage.

## Interface
- DATA_BITS, 64: input/output width per lane; ≥ 8.
- MANT_BITS, 4: retained significant bits; 2 ≤ MANT_BITS ≤ DATA_BITS-1.
- LANES, 4: parallel channels.
- EXP_BITS, $clog2(DATA_BITS): derived exponent width; not overridden.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous assert, active-high.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o.
- in_data_i  in  LANES*DATA_BITS  signed operands; lane k is bits [k*DATA_BITS +: DATA_BITS].
- out_valid_o  out  1  result beat valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  LANES*DATA_BITS  unsigned approximated magnitude = mant << exp.
- out_mant_o  out  LANES*MANT_BITS  retained mantissa; MSB is set unless the value is exact and small.
- out_exp_o  out  LANES*EXP_BITS  shift amount.
- out_sign_o  out  LANES  input MSB.
- out_zero_o  out  LANES  input equals 0.

## Operation
- Magnitude: u = MSB ? -x : x, held as a DATA_BITS-bit unsigned value. The most-negative input gives u = 2^(DATA_BITS-1) exactly.
- Leading-one position p. u == 0 → zero flag = 1; mant, exp and data = 0; sign = 0.
- Small value, p < MANT_BITS: exact result; exp = 0, mant = u, data = u.
- Otherwise:
  - exp = p-MANT_BITS+1.
  - mant = u[p -: MANT_BITS].
  - Rounding adds bit u[exp-1].
  - Mantissa carry-out: mant = 1<<(MANT_BITS-1), exp += 1.
- No output overflow: u ≤ 2^(DATA_BITS-1), so the rounded value always fits in DATA_BITS bits.
- Lanes are independent in arithmetic and lockstep in handshake.
- Stage 1 registers: u, p, zero flag, sign.
- Stage 2 registers: rounded mant, exp, data, zero flag, sign.
- Stage advance rule: a stage loads when it is empty or the stage after it is being drained in the same cycle.
- in_ready_o is combinational: !s1_valid | s2_load.
- Stage 2 drains when out_valid_o & out_ready_i.

## Timing
- Latency: 2 cycles from input handshake to out_valid_o, with no stall.
- Throughput: 1 beat/cycle while out_ready_i = 1.
- Stalled output: all out_* held stable until accepted.
- Pipeline capacity: 2 beats. With out_ready_i low, in_ready_o falls once both stages are valid.
- Simultaneous accept and drain on a full pipe: no bubble, no loss.
- Reset values: out_valid_o = 0 and every out_* data/flag = 0. in_ready_o = 1 immediately after reset.
- Reset mid-operation: in-flight beats are discarded and not replayed.
- Datapath registers load only on advance, so no X propagates from an idle in_data_i.

## Configuration
- AME_APPROX_ROUND_EN defined: round-to-nearest with half-up, carry handling as above.
- AME_APPROX_ROUND_EN undefined: truncation. Never a carry, exp = max(p-MANT_BITS+1, 0). The rounding adder is not synthesised.

## Structure
- Package ame_approx_pkg holds:
  - lane result struct typedef (data, mant, exp, sign, zero), parametrised through package localparams for the default configuration;
  - the exp-width helper constant.
- Sub-module ame_lzd: parametrised leading-one detector (DATA_BITS in → position + zero flag), one instance per lane, combinational. Stage registers stay in the top module.

## Test plan
Defaults unless noted: DATA_BITS=64, MANT_BITS=4, LANES=4, rounding enabled unless noted.
- Lanes {0xB7, -0xB7, 0, 5}, out_ready_i=1:
  - after 2 cycles, data {176, 176, 0, 5};
  - sign {0,1,0,0}; zero {0,0,1,0};
  - exp {4,4,0,0}; mant {0xB,0xB,0,5}.
- Rounding with lane0 = 0xBC, lane1 = 0xF8:
  - with macro: 0xBC → 192 (mant 0xC, exp 4); 0xF8 → 256 (mant 0x8, exp 5);
  - without macro: 176 and 240.
- Extreme values: lane0 = 0x8000_0000_0000_0000 → data 0x8000_0000_0000_0000, sign 1, mant 0x8, exp 60. Lane1 = 0x7FFF_FFFF_FFFF_FFFF with rounding → data 2^63, exp 60.
- Backpressure:
  - 5 back-to-back beats with out_ready_i low for 4 cycles: in_ready_o drops after 2 accepted;
  - outputs stay stable while stalled;
  - once released, all 5 results emerge in order, no duplicates or loss.
- Random valid/ready toggling, 10k beats: scoreboard against a reference model. Beats in equal beats out.
- rst_i asserted while 2 beats are in flight: out_valid_o falls to 0 asynchronously and all outputs read 0. After release, the next beat completes with 2-cycle latency and no stale result appears.
